// File: rtl/mmio_store_sink_if.sv
// Bus bundle between the core's M-stage data port, the store sink and its drain consumer.
interface mmio_store_sink_if;
  logic        MemWriteM;
  logic [31:0] DataAdrM;
  logic [31:0] WriteData;
  logic [31:0] ReadDataM;
  logic        HitM;
  logic [31:0] DrainData;
  logic        DrainValid;
  logic        DrainReady;
  logic        Done;
  logic [31:0] ExitCode;
  logic        Overflow;

  modport master (
    output MemWriteM, DataAdrM, WriteData, DrainReady,
    input  ReadDataM, HitM, DrainData, DrainValid, Done, ExitCode, Overflow
  );

  modport slave (
    input  MemWriteM, DataAdrM, WriteData, DrainReady,
    output ReadDataM, HitM, DrainData, DrainValid, Done, ExitCode, Overflow
  );
endinterface

// File: rtl/mmio_store_sink.sv
// MMIO store sink: TXDATA FIFO with valid/ready drain, STATUS, sticky TOHOST and CTRL flush.
// Optional STORES/DROPS counters at 0x10/0x14 are built when MMIO_SINK_STATS_EN is defined.
module mmio_store_sink #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int          DEPTH     = 8,
  localparam int         CW        = $clog2(DEPTH) + 1
) (
  input logic               clk,
  input logic               reset,
  mmio_store_sink_if.slave  bus
);

  localparam int PW = CW - 1;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;
  logic [31:0]   exit_code_q, exit_code_d;
  logic          overflow_q, overflow_d;

  logic          hit_s, wr_s, push_req_s, push_ok_s, pop_s, drop_s;
  logic          flush_s, tohost_wr_s, full_s, empty_s;
  logic [2:0]    sel_s;
  logic [31:0]   head_s, status_s, rdata_s;
  logic [1:0]    unused_byte_sel_s;

  assign unused_byte_sel_s = bus.DataAdrM[1:0];

  assign hit_s       = (bus.DataAdrM[31:5] == BASE_ADDR[31:5]);
  assign sel_s       = bus.DataAdrM[4:2];
  assign wr_s        = bus.MemWriteM & hit_s;
  assign full_s      = (count_q == CW'(DEPTH));
  assign empty_s     = (count_q == {CW{1'b0}});
  assign pop_s       = ~empty_s & bus.DrainReady;
  assign push_req_s  = wr_s & (sel_s == 3'd0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok_s   = push_req_s & (~full_s | pop_s);
  assign drop_s      = push_req_s & full_s & ~pop_s;
  assign flush_s     = wr_s & (sel_s == 3'd3) & bus.WriteData[0];
  assign tohost_wr_s = wr_s & (sel_s == 3'd2) & ~done_q;

  assign head_s   = empty_s ? 32'h0000_0000 : mem_q[rd_ptr_q];
  assign status_s = {overflow_q, done_q, full_s, empty_s, 20'h0_0000, 8'(count_q)};

`ifdef MMIO_SINK_STATS_EN
  logic [31:0] stores_q, drops_q;

  // Statistics counters, cleared by flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stores_q <= 32'h0000_0000;
      drops_q  <= 32'h0000_0000;
    end else if (flush_s) begin
      stores_q <= 32'h0000_0000;
      drops_q  <= 32'h0000_0000;
    end else begin
      stores_q <= stores_q + {31'h0000_0000, push_ok_s};
      drops_q  <= drops_q + {31'h0000_0000, drop_s};
    end
  end
`endif

  // Next-state for pointers, occupancy and sticky status bits.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    done_d      = done_q;
    exit_code_d = exit_code_q;
    // Flush overrides a concurrent pop; that popped word still counts as delivered.
    if (flush_s) begin
      wr_ptr_d   = {PW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
      count_d    = {CW{1'b0}};
      overflow_d = 1'b0;
    end else begin
      wr_ptr_d   = wr_ptr_q + PW'(push_ok_s);
      rd_ptr_d   = rd_ptr_q + PW'(pop_s);
      count_d    = count_q + CW'(push_ok_s) - CW'(pop_s);
      overflow_d = overflow_q | drop_s;
    end
    if (tohost_wr_s) begin
      done_d      = 1'b1;
      exit_code_d = bus.WriteData;
    end else begin
      done_d      = done_q;
      exit_code_d = exit_code_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      exit_code_q <= 32'h0000_0000;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      exit_code_q <= exit_code_d;
    end
  end

  // FIFO storage; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= bus.WriteData;
    end
  end

  // Load data mux over the window registers.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (sel_s)
      3'd0:    rdata_s = head_s;
      3'd1:    rdata_s = status_s;
      3'd2:    rdata_s = exit_code_q;
`ifdef MMIO_SINK_STATS_EN
      3'd4:    rdata_s = stores_q;
      3'd5:    rdata_s = drops_q;
`endif
      default: rdata_s = 32'h0000_0000;
    endcase
  end

  assign bus.HitM       = hit_s;
  assign bus.ReadDataM  = hit_s ? rdata_s : 32'h0000_0000;
  assign bus.DrainData  = head_s;
  assign bus.DrainValid = ~empty_s;
  assign bus.Done       = done_q;
  assign bus.ExitCode   = exit_code_q;
  assign bus.Overflow   = overflow_q;

endmodule

// File: tb/tb_mmio_store_sink.sv
// Self-checking bench for mmio_store_sink: drain scoreboard plus register read-back checks.
module tb_mmio_store_sink;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_q [$];
  logic [31:0] rd;

  mmio_store_sink_if bus ();

  mmio_store_sink #(.BASE_ADDR(32'h0000_0100), .DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.MemWriteM = 1'b1;
    bus.DataAdrM  = a;
    bus.WriteData = d;
    cyc();
    bus.MemWriteM = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] v);
    bus.MemWriteM = 1'b0;
    bus.DataAdrM  = a;
    #1;
    v = bus.ReadDataM;
  endtask

  // Scoreboard: every accepted drain word must match the oldest expected word.
  always @(negedge clk) begin
    if (reset && bus.DrainValid && bus.DrainReady) begin
      chk("drain_expected", {31'h0, exp_q.size() != 0}, 32'h1);
      if (exp_q.size() != 0) begin
        chk("drain_data", bus.DrainData, exp_q.pop_front());
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset          = 1'b0;
    bus.MemWriteM  = 1'b0;
    bus.DataAdrM   = 32'h0000_0000;
    bus.WriteData  = 32'h0000_0000;
    bus.DrainReady = 1'b0;
    #3;
    chk("rst_valid", {31'h0, bus.DrainValid}, 32'h0);
    chk("rst_data", bus.DrainData, 32'h0);
    chk("rst_done", {31'h0, bus.Done}, 32'h0);
    chk("rst_exit", bus.ExitCode, 32'h0);
    chk("rst_ovf", {31'h0, bus.Overflow}, 32'h0);
    #9 reset = 1'b1;
    cyc();

    // Basic store and drain, one word per cycle.
    bus.DrainReady = 1'b1;
    exp_q.push_back(32'h41);
    store(32'h100, 32'h41);
    @(negedge clk);
    chk("lat_valid", {31'h0, bus.DrainValid}, 32'h1);
    chk("lat_data", bus.DrainData, 32'h41);
    cyc();
    exp_q.push_back(32'h42);
    store(32'h100, 32'h42);
    exp_q.push_back(32'h43);
    store(32'h100, 32'h43);
    cyc();
    cyc();
    load(32'h104, rd);
    chk("t1_status", rd, 32'h1000_0000);
    chk("t1_sb_empty", exp_q.size(), 32'h0);

    // Overflow with consumer stalled.
    store(32'h10C, 32'h1);
    bus.DrainReady = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(32'(i));
      store(32'h100, 32'(i));
    end
    load(32'h104, rd);
    chk("t2_status", rd, 32'hA000_0008);
    chk("t2_ovf", {31'h0, bus.Overflow}, 32'h1);
`ifdef MMIO_SINK_STATS_EN
    load(32'h110, rd);
    chk("t2_stores", rd, 32'h8);
    load(32'h114, rd);
    chk("t2_drops", rd, 32'h1);
`endif

    // Push while full together with a pop.
    bus.DrainReady = 1'b1;
    exp_q.push_back(32'hAA);
    store(32'h100, 32'hAA);
    bus.DrainReady = 1'b0;
    load(32'h104, rd);
    chk("t3_status", rd, 32'hA000_0008);
    bus.DrainReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    chk("t3_drained", exp_q.size(), 32'h0);
    load(32'h104, rd);
    chk("t3_status_end", rd, 32'h9000_0000);

    // Tohost: first write wins.
    store(32'h108, 32'h1);
    chk("t4_done", {31'h0, bus.Done}, 32'h1);
    chk("t4_exit", bus.ExitCode, 32'h1);
    store(32'h108, 32'h5);
    chk("t4_exit_keep", bus.ExitCode, 32'h1);
    load(32'h108, rd);
    chk("t4_load", rd, 32'h1);

    // Flush with a concurrent pop.
    bus.DrainReady = 1'b0;
    exp_q.push_back(32'h11);
    store(32'h100, 32'h11);
    exp_q.push_back(32'h22);
    store(32'h100, 32'h22);
    exp_q.push_back(32'h33);
    store(32'h100, 32'h33);
    load(32'h104, rd);
    chk("t5_status_pre", rd, 32'hC000_0003);
    bus.DrainReady = 1'b1;
    store(32'h10C, 32'h1);
    exp_q.delete();
    chk("t5_valid", {31'h0, bus.DrainValid}, 32'h0);
    chk("t5_ovf", {31'h0, bus.Overflow}, 32'h0);
    load(32'h104, rd);
    chk("t5_status", rd, 32'h5000_0000);
    load(32'h10C, rd);
    chk("t5_ctrl_rd", rd, 32'h0);
    load(32'h118, rd);
    chk("t5_rsvd_rd", rd, 32'h0);
    load(32'h110, rd);
    chk("t5_stores_rd", rd, 32'h0);

    // Out-of-window store, then reset mid-drain.
    bus.MemWriteM = 1'b1;
    bus.DataAdrM  = 32'h200;
    bus.WriteData = 32'h77;
    #1;
    chk("t6_hit", {31'h0, bus.HitM}, 32'h0);
    cyc();
    bus.MemWriteM = 1'b0;
    chk("t6_nopush", {31'h0, bus.DrainValid}, 32'h0);
    bus.DrainReady = 1'b0;
    exp_q.push_back(32'h55);
    store(32'h100, 32'h55);
    exp_q.push_back(32'h66);
    store(32'h100, 32'h66);
    bus.DrainReady = 1'b1;
    bus.DataAdrM = 32'h108;
    cyc();
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", {31'h0, bus.DrainValid}, 32'h0);
    chk("t6_rst_data", bus.DrainData, 32'h0);
    chk("t6_rst_done", {31'h0, bus.Done}, 32'h0);
    chk("t6_rst_exit", bus.ExitCode, 32'h0);
    chk("t6_rst_ovf", {31'h0, bus.Overflow}, 32'h0);
    chk("t6_rst_rdata", bus.ReadDataM, 32'h0);
    exp_q.delete();
    #10 reset = 1'b1;
    cyc();
    cyc();
    chk("t6_post_valid", {31'h0, bus.DrainValid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
